// File: rtl/libhdl_stream_checker.sv
// libhdl_stream_checker
// Sink-side checker for valid/ready streams carrying a Galois-LFSR word
// sequence. Locks onto the first nonzero word, predicts every following word,
// and counts checked words and mismatches (both saturating). Lock is dropped
// after LOSS_THRESH consecutive mismatches.
// Optional feature: define LIBHDL_STREAM_CHECKER_THROTTLE_EN to add
// pseudo-random backpressure on o_rdy (16-bit Fibonacci LFSR, ~25% low).
module libhdl_stream_checker #(
    parameter int                  DATA_LEN    = 32,
    parameter logic [DATA_LEN-1:0] POLY        = 'h80200003,
    parameter int                  CNT_LEN     = 32,
    parameter int                  LOSS_THRESH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ena,
    input  logic                i_clr,
    input  logic                i_vld,
    output logic                o_rdy,
    input  logic [DATA_LEN-1:0] i_dat,
    output logic                o_locked,
    output logic                o_err,
    output logic [CNT_LEN-1:0]  o_word_cnt,
    output logic [CNT_LEN-1:0]  o_err_cnt
);

    typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

    state_t                state_q;
    logic                  rdy_q;
    logic                  locked_q;
    logic                  err_q;
    logic [CNT_LEN-1:0]    word_cnt_q;
    logic [CNT_LEN-1:0]    err_cnt_q;
    logic [DATA_LEN-1:0]   exp_q;
    logic [7:0]            miss_q;
    logic [1:0]            rst_sync_q;
    logic                  rst_int_n;
    logic                  xfer;
    logic                  rdy_ok;
    logic                  last_miss;

    function automatic logic [DATA_LEN-1:0] lfsr_next(input logic [DATA_LEN-1:0] x);
        return (x >> 1) ^ (x[0] ? POLY : '0);
    endfunction

    function automatic logic [CNT_LEN-1:0] sat_inc(input logic [CNT_LEN-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Reset asserts asynchronously, releases two clocks after the pin goes high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

`ifdef LIBHDL_STREAM_CHECKER_THROTTLE_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Taps 16,14,13,11; o_rdy is registered, so gate it with the value the
    // LFSR takes on the same edge to line the low cycles up with lfsr==xx00
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign rdy_ok = (lfsr_d[1:0] != 2'b00);

    // Free-running throttle LFSR
    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) lfsr_q <= 16'hACE1;
        else            lfsr_q <= lfsr_d;
    end
`else
    assign rdy_ok = 1'b1;
`endif

    assign xfer      = i_vld && rdy_q;
    assign last_miss = (miss_q + 8'd1) == 8'(LOSS_THRESH);

    // Checker FSM with registered ready/lock/error outputs and counters
    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            exp_q      <= '0;
            miss_q     <= '0;
        end else begin
            err_q <= 1'b0;
            if (i_clr) begin
                // Any word offered this cycle is dropped; expected is kept
                word_cnt_q <= '0;
                err_cnt_q  <= '0;
                miss_q     <= '0;
                locked_q   <= 1'b0;
                state_q    <= i_ena ? SYNC : IDLE;
                rdy_q      <= i_ena && rdy_ok;
            end else if (!i_ena) begin
                state_q  <= IDLE;
                rdy_q    <= 1'b0;
                locked_q <= 1'b0;
            end else begin
                rdy_q <= rdy_ok;
                case (state_q)
                    IDLE: begin
                        state_q  <= SYNC;
                        locked_q <= 1'b0;
                    end
                    SYNC: begin
                        // Zero words carry no sequence position; skip them
                        if (xfer && (i_dat != '0)) begin
                            exp_q    <= lfsr_next(i_dat);
                            miss_q   <= '0;
                            state_q  <= CHECK;
                            locked_q <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (xfer) begin
                            word_cnt_q <= sat_inc(word_cnt_q);
                            exp_q      <= lfsr_next(exp_q);
                            if (i_dat == exp_q) begin
                                miss_q <= '0;
                            end else begin
                                err_cnt_q <= sat_inc(err_cnt_q);
                                err_q     <= 1'b1;
                                if (last_miss) begin
                                    miss_q   <= '0;
                                    state_q  <= SYNC;
                                    locked_q <= 1'b0;
                                end else begin
                                    miss_q <= miss_q + 8'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rdy      = rdy_q;
    assign o_locked   = locked_q;
    assign o_err      = err_q;
    assign o_word_cnt = word_cnt_q;
    assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_libhdl_stream_checker.sv
// Directed bench for libhdl_stream_checker: a 32-bit-counter instance and a
// 4-bit-counter instance share all inputs so saturation is observed alongside.
module tb_libhdl_stream_checker;

    localparam logic [31:0] POLY = 32'h80200003;
    localparam int          WAIT_MAX = 64;

    logic        clk = 1'b0;
    logic        rst_n, ena, clr, vld;
    logic [31:0] dat;
    logic        rdy, locked, err;
    logic [31:0] wc, ec;
    logic        rdy4, locked4, err4;
    logic [3:0]  wc4, ec4;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_pulses = 0;
    logic [31:0] x;

    always #5 clk = ~clk;

    libhdl_stream_checker u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_clr(clr), .i_vld(vld),
        .o_rdy(rdy), .i_dat(dat), .o_locked(locked), .o_err(err),
        .o_word_cnt(wc), .o_err_cnt(ec)
    );

    libhdl_stream_checker #(.CNT_LEN(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_clr(clr), .i_vld(vld),
        .o_rdy(rdy4), .i_dat(dat), .o_locked(locked4), .o_err(err4),
        .o_word_cnt(wc4), .o_err_cnt(ec4)
    );

    always @(negedge clk) if (err === 1'b1) err_pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 32'h0);
    endfunction

    // Offer one word, hold it until accepted, return #1 after the accepting edge
    task automatic send(input logic [31:0] w);
        int n = 0;
        vld = 1'b1;
        dat = w;
        while (!rdy && n < WAIT_MAX) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rdy_wait", 64'(n < WAIT_MAX), 64'd1);
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; clr = 1'b0; vld = 1'b0; dat = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", rdy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_wc", wc, 0);
        chk("rst_ec", ec, 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // 1: 100 clean words from seed 1
        x = 32'h1;
        for (int i = 0; i < 100; i++) begin
            send(x);
            if (i == 0) chk("t1_lock", locked, 1);
            x = nxt(x);
        end
        chk("t1_wc", wc, 99);
        chk("t1_ec", ec, 0);
        chk("t1_pulses", err_pulses, 0);
        chk("t6_wc4_sat", wc4, 4'hF);
        chk("t6_ec4", ec4, 0);

        // 2: single bit error on word 40
        for (int i = 1; i <= 41; i++) begin
            send((i == 40) ? (x ^ 32'h1) : x);
            if (i == 40) begin
                chk("t2_err", err, 1);
                chk("t2_lock", locked, 1);
                chk("t2_ec", ec, 1);
            end
            if (i == 41) chk("t2_err41", err, 0);
            x = nxt(x);
        end
        chk("t2_pulses", err_pulses, 1);
        chk("t2_wc", wc, 140);

        // 3: four consecutive bad words drop lock, two good words relock
        for (int i = 0; i < 4; i++) begin
            send(x ^ 32'hFFFF_0000);
            x = nxt(x);
            if (i == 2) chk("t3_lock3", locked, 1);
            if (i == 3) begin
                chk("t3_unlock", locked, 0);
                chk("t3_ec", ec, 5);
            end
        end
        send(x); x = nxt(x);
        chk("t3_relock", locked, 1);
        send(x); x = nxt(x);
        chk("t3_err_ok", err, 0);
        chk("t3_lock2", locked, 1);
        chk("t3_wc", wc, 145);
        chk("t3_ec_hold", ec, 5);
        chk("t3_ec4", ec4, 5);
        chk("t3_pulses", err_pulses, 5);

        // 4: disable/enable returns to SYNC; zero ignored; lock on 5
        ena = 1'b0;
        @(posedge clk); #1;
        chk("t4_dis_lock", locked, 0);
        chk("t4_dis_rdy", rdy, 0);
        ena = 1'b1;
        send(32'h0);
        chk("t4_zero_lock", locked, 0);
        chk("t4_zero_wc", wc, 145);
        send(32'h5);
        chk("t4_lock5", locked, 1);
        send(32'h8020_0001);
        chk("t4_next5", err, 0);
        chk("t4_wc", wc, 146);
        x = nxt(32'h8020_0001);

        // 5: gappy stream, then clear with a dropped word, then reset mid-transfer
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(x);
            x = nxt(x);
        end
        chk("t5_wc", wc, 156);
        chk("t5_ec", ec, 5);
        chk("t5_lock", locked, 1);
        clr = 1'b1; vld = 1'b1; dat = x;
        @(posedge clk); #1;
        clr = 1'b0; vld = 1'b0;
        chk("t5_clr_wc", wc, 0);
        chk("t5_clr_ec", ec, 0);
        chk("t5_clr_err", err, 0);
        chk("t5_clr_lock", locked, 0);
        chk("t5_clr_wc4", wc4, 0);
        x = 32'h1234_5678;
        send(x); x = nxt(x);
        send(x); x = nxt(x);
        chk("t5_relock", locked, 1);
        chk("t5_relock_wc", wc, 1);
        chk("t5_relock_ec", ec, 0);

        vld = 1'b1; dat = x;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rdy", rdy, 0);
        chk("t5_rst_lock", locked, 0);
        chk("t5_rst_err", err, 0);
        chk("t5_rst_wc", wc, 0);
        chk("t5_rst_ec", ec, 0);
        chk("t5_rst_wc4", wc4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
